// File: rtl/regfile_syscall.sv
// Register file with syscall decode: 31 x 32-bit registers, a RUN/HALTED FSM,
// an LED output register loaded by code 34 and a saturating syscall counter.
module regfile_syscall #(
    parameter int unsigned CNT_W = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [4:0]        R1Adr,
    input  logic [4:0]        R2Adr,
    input  logic [4:0]        WAdr,
    input  logic [31:0]       RDin,
    input  logic              RegWrite,
    input  logic              Syscall,
    output logic [31:0]       R1,
    output logic [31:0]       R2,
    output logic              Halt,
    output logic [31:0]       LedData,
    output logic [CNT_W-1:0]  SysCnt
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREG   = 32;

    localparam logic [DATA_W-1:0] SYS_EXIT = DATA_W'(10);
    localparam logic [DATA_W-1:0] SYS_LED  = DATA_W'(34);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [DATA_W-1:0]       led_d;
    logic [CNT_W-1:0]        cnt_d;
    logic                    wr_en_c;
    logic [DATA_W-1:0]       regs [1:NREG-1];

    // Zero-latency reads; register 0 has no storage and reads as zero.
    always_comb begin
        R1 = '0;
        R2 = '0;
        if (R1Adr != ADDR_W'(0)) R1 = regs[R1Adr];
        if (R2Adr != ADDR_W'(0)) R2 = regs[R2Adr];
    end

    assign wr_en_c = RegWrite && (WAdr != ADDR_W'(0)) && (state_q == RUN);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 1; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en_c) begin
            regs[WAdr] <= RDin;
        end
    end

    // Syscall decode uses the pre-edge read values, so a coinciding write
    // never influences the code or the LED payload.
    always_comb begin
        state_d = state_q;
        led_d   = LedData;
        cnt_d   = SysCnt;
        if (state_q == RUN && Syscall) begin
            if (SysCnt != '1) cnt_d = SysCnt + CNT_W'(1);
            if (R1 == SYS_EXIT) begin
                state_d = HALTED;
            end else if (R1 == SYS_LED) begin
                led_d = R2;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            LedData <= '0;
            SysCnt  <= '0;
        end else begin
            state_q <= state_d;
            LedData <= led_d;
            SysCnt  <= cnt_d;
        end
    end

    assign Halt = (state_q == HALTED);

endmodule

// File: doc/regfile_syscall.md
REGFILE_SYSCALL -- requirements
Module: regfile_syscall

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the syscall counter.
REQ-002 SHALL have port CLK  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port nRST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port R1Adr  input  5  read port 1 address; during syscall the upstream stage drives 2 ($v0).
REQ-005 SHALL have port R2Adr  input  5  read port 2 address; during syscall the upstream stage drives 4 ($a0).
REQ-006 SHALL have port WAdr  input  5  write address (rd, rt or 31 for JAL).
REQ-007 SHALL have port RDin  input  32  write data (writeback data or PC+4).
REQ-008 SHALL have port RegWrite  input  1  write enable.
REQ-009 SHALL have port Syscall  input  1  the current instruction is a syscall.
REQ-010 SHALL have port R1  output  32  read data for port 1.
REQ-011 SHALL have port R2  output  32  read data for port 2.
REQ-012 SHALL have port Halt  output  1  program stopped; the PC stage gates its clock enable with this.
REQ-013 SHALL have port LedData  output  32  last value printed by syscall 34.
REQ-014 SHALL have port SysCnt  output  CNT_W  number of accepted syscalls.

Function
REQ-015 SHALL hold 31 32-bit registers for addresses 1..31; address 0 SHALL always read as 0 and SHALL have no storage.
REQ-016 SHALL drive R1/R2 combinationally from the current register contents (zero latency) without write-through bypass; a same-cycle write SHALL become visible only after the rising edge.
REQ-017 SHALL write RDin to register WAdr on the rising CLK edge when RegWrite=1, WAdr!=0 and Halt=0.
REQ-018 SHALL ignore writes to WAdr=0 with no side effects.
REQ-019 SHALL run a two-state FSM: RUN and HALTED; reset enters RUN.
REQ-020 SHALL, in RUN with Syscall=1 at a rising edge, decode R1 ($v0): value 10 moves to HALTED; value 34 loads LedData<=R2; any other value is a no-op.
REQ-021 SHALL increment SysCnt on every syscall accepted in RUN, including codes 10, 34 and unknown codes, and SHALL saturate at all-ones without wrapping.
REQ-022 SHALL drive Halt=1 exactly while in HALTED, starting the cycle after the halting edge.
REQ-023 SHALL, in HALTED, ignore RegWrite and Syscall; registers, LedData and SysCnt SHALL hold until reset.
REQ-024 SHALL, when a syscall and RegWrite coincide in RUN, decode the syscall from pre-write values and still commit the write, even when the syscall is code 10.
REQ-025 SHALL stay purely combinational on the read path; the Syscall decode SHALL sample R1/R2 at the edge.

Reset
REQ-026 SHALL, while nRST=0 and immediately without waiting for CLK, clear all registers, LedData and SysCnt to 0, set Halt=0 and force the FSM to RUN.
REQ-027 SHALL, on reset asserted mid-operation (including in HALTED), abort any pending write; the first write after release SHALL occur at the first rising edge with nRST=1.

Verification
REQ-028 SHALL cover: write 0xDEADBEEF to reg 5, then read R1Adr=5 -> R1=0xDEADBEEF next cycle, and R1 still holds its old value in the write cycle.
REQ-029 SHALL cover: write 0x12345678 to reg 0, then read R1Adr=0 -> R1=0, with no other register changed.
REQ-030 SHALL cover: reg2=34, reg4=0x00C0FFEE, Syscall pulse -> LedData=0x00C0FFEE, SysCnt=1, Halt=0.
REQ-031 SHALL cover: reg2=10, Syscall plus RegWrite of 0x55 to reg 9 in the same cycle -> reg9=0x55, Halt=1 next cycle, SysCnt=1, and later writes and syscalls are ignored.
REQ-032 SHALL cover: CNT_W=4 with 20 syscalls carrying unknown code 7 -> SysCnt saturates at 15.
REQ-033 SHALL cover: nRST pulsed low between clock edges while HALTED -> Halt, SysCnt and LedData read 0 before the next edge, and all registers read 0.
